// File: rtl/aes_inv_cipher_iter.sv
// AES-128 inverse cipher, one round per clock, with an internal key-expansion engine holding all 11 round keys.
// Latency: key load 10 cycles; a block's out_valid rises on the 10th rising edge after its accept edge.
// Backpressure: valid/ready on all three channels, one block in flight; DONE holds until out_ready. Optional abort via AES_DEC_ABORT_EN.
module aes_inv_cipher_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
`ifdef AES_DEC_ABORT_EN
    input  logic         abort,
`endif
    output logic [127:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KEYEXP = 3'd1,
        READY  = 3'd2,
        BUSY   = 3'd3,
        DONE   = 3'd4
    } fsm_t;

    // Byte k of a block (byte 0 at the MSB) lives at index 15-k of this view.
    typedef logic [15:0][7:0] bytes_t;
    typedef logic [3:0][31:0] cols_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Entry b sits at bit offset (255-b)*8, and 255-b is simply ~b for a byte.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        a[0] = c[31:24];
        a[1] = c[23:16];
        a[2] = c[15:8];
        a[3] = c[7:0];
        for (int i = 0; i < 4; i++) begin
            x2[i[1:0]] = xtime(a[i[1:0]]);
            x4[i[1:0]] = xtime(x2[i[1:0]]);
            x8[i[1:0]] = xtime(x4[i[1:0]]);
            m9[i[1:0]] = x8[i[1:0]] ^ a[i[1:0]];
            mb[i[1:0]] = x8[i[1:0]] ^ x2[i[1:0]] ^ a[i[1:0]];
            md[i[1:0]] = x8[i[1:0]] ^ x4[i[1:0]] ^ a[i[1:0]];
            me[i[1:0]] = x8[i[1:0]] ^ x4[i[1:0]] ^ x2[i[1:0]];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        cols_t y;
        cols_t o;
        y = s;
        for (int c = 0; c < 4; c++) o[c[1:0]] = inv_mix_col(y[c[1:0]]);
        return o;
    endfunction

    // Row r rotates right by r columns; written as a fixed byte permutation.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        bytes_t x;
        x = s;
        return {x[15], x[2],  x[5],  x[8],
                x[11], x[14], x[1],  x[4],
                x[7],  x[10], x[13], x[0],
                x[3],  x[6],  x[9],  x[12]};
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        bytes_t x;
        bytes_t o;
        x = s;
        for (int i = 0; i < 16; i++) o[i[3:0]] = inv_sbox(x[i[3:0]]);
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] expand_key(input logic [127:0] prev, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        {w0, w1, w2, w3} = prev;
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    fsm_t         fsm;
    logic [3:0]   rnd;
    logic [127:0] blk;
    logic [127:0] rk [0:10];

    logic [127:0] key_step;
    logic [127:0] round_last;
    logic [127:0] round_mid;

    // During KEYEXP rnd names the key being produced; during BUSY it names the key being applied.
    assign key_step   = expand_key(rk[rnd - 4'd1], rcon(rnd));
    assign round_last = inv_sub_bytes(inv_shift_rows(blk)) ^ rk[rnd];
    assign round_mid  = inv_mix_columns(round_last);

    // Data has priority over a new key in READY, so key_ready drops while in_valid is high.
    assign key_ready = ~rst & ((fsm == IDLE) | ((fsm == READY) & ~in_valid));
    assign in_ready  = (fsm == READY);
    assign out_valid = (fsm == DONE);

    // Control FSM, key schedule, round datapath and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm      <= IDLE;
            rnd      <= '0;
            blk      <= '0;
            out_data <= '0;
            rk       <= '{default: '0};
        end else begin
`ifdef AES_DEC_ABORT_EN
            if (abort && fsm == KEYEXP) begin
                fsm <= IDLE;
            end else if (abort && (fsm == BUSY || fsm == DONE)) begin
                fsm <= READY;
            end else
`endif
            begin
                case (fsm)
                    IDLE: begin
                        if (key_valid) begin
                            rk[0] <= key_in;
                            rnd   <= 4'd1;
                            fsm   <= KEYEXP;
                        end
                    end
                    KEYEXP: begin
                        rk[rnd] <= key_step;
                        if (rnd == 4'd10) begin
                            fsm <= READY;
                        end else begin
                            rnd <= rnd + 4'd1;
                        end
                    end
                    READY: begin
                        if (in_valid) begin
                            blk <= in_data ^ rk[10];
                            rnd <= 4'd9;
                            fsm <= BUSY;
                        end else if (key_valid) begin
                            rk[0] <= key_in;
                            rnd   <= 4'd1;
                            fsm   <= KEYEXP;
                        end
                    end
                    BUSY: begin
                        if (rnd != 4'd0) begin
                            blk <= round_mid;
                            rnd <= rnd - 4'd1;
                        end else begin
                            blk      <= round_last;
                            out_data <= round_last;
                            fsm      <= DONE;
                        end
                    end
                    DONE: begin
                        if (out_ready) begin
                            fsm <= READY;
                        end
                    end
                    default: fsm <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/aes_inv_cipher_iter.md
AES_INV_CIPHER_ITER -- requirements
Module: aes_inv_cipher_iter

Interface
REQ-001 Parameters: none; the block is fixed to AES-128 (Nk=4, Nr=10).
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 key_in  in  128  cipher key, byte 0 at [127:120].
REQ-005 key_valid  in  1  key_in offered.
REQ-006 key_ready  out  1  key accepted when key_valid && key_ready.
REQ-007 in_data  in  128  ciphertext block, byte 0 at [127:120], column-major state.
REQ-008 in_valid  in  1  ciphertext offered.
REQ-009 in_ready  out  1  ciphertext accepted when in_valid && in_ready.
REQ-010 out_data  out  128  plaintext block, same byte order.
REQ-011 out_valid  out  1  out_data valid.
REQ-012 out_ready  in  1  consumer takes out_data when out_valid && out_ready.
REQ-013 abort  in  1  cancel in-flight operation; present only with AES_DEC_ABORT_EN.

Function
REQ-014 FSM states: IDLE (no key), KEYEXP, READY, BUSY, DONE.
REQ-015 key_ready = (IDLE) or (READY and not in_valid); in_ready = READY; out_valid = DONE.
REQ-016 IDLE/READY + key accept: rk0 <= key_in, round counter <= 1, go KEYEXP.
REQ-017 KEYEXP: one round key per cycle, rk[i] from rk[i-1] via RotWord, SubWord and Rcon(i) (01,02,04,08,10,20,40,80,1b,36); after the edge that writes rk10 go READY; 10 cycles total.
REQ-018 All 11 round keys are held in registers until the next key accept or reset.
REQ-019 READY with in_valid and key_valid both high: data wins; the key is not accepted (key_ready low).
REQ-020 READY + data accept: state <= in_data XOR rk10, round <= 9, go BUSY.
REQ-021 BUSY, round r = 9..1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) XOR rk[r]), r decrements.
REQ-022 BUSY, r = 0: state <= InvSubBytes(InvShiftRows(state)) XOR rk0, go DONE.
REQ-023 Latency: out_valid rises on the 10th rising edge after the accept edge.
REQ-024 DONE: out_data and out_valid hold stable until out_ready; on the handshake edge go READY; in_ready is not high in the same cycle (no overlap, one block in flight).
REQ-025 out_data holds its last value outside DONE; it is only meaningful while out_valid is high.
REQ-026 key_valid is ignored in KEYEXP, BUSY and DONE; in_valid is ignored outside READY.

Reset
REQ-027 rst high at a clock edge: state IDLE, round keys, state register and counter cleared to 0.
REQ-028 Outputs under rst: key_ready 0, in_ready 0, out_valid 0, out_data 0; key_ready goes high in the first cycle after rst deasserts.
REQ-029 rst in any state, including mid-KEYEXP or mid-BUSY, discards all work; a new key is required before data.

Configuration
REQ-030 Macro AES_DEC_ABORT_EN defined: abort port exists, and abort has priority over all events except rst.
REQ-031 abort in KEYEXP: go IDLE. abort in BUSY or DONE: go READY, no out_valid produced, round keys kept. abort in IDLE or READY: no effect.
REQ-032 Macro AES_DEC_ABORT_EN undefined: no abort port and no abort logic; behaviour is otherwise identical.

Verification
REQ-033 key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff, out_valid on the 10th edge after accept.
REQ-034 key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734; rk10 is d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-035 out_ready held low for 5 cycles in DONE -> out_data and out_valid stable; in_ready low; no second accept.
REQ-036 READY with key_valid and in_valid both high -> data accepted, old key used, key_ready low that cycle.
REQ-037 rst asserted on the 5th BUSY cycle -> next cycle all outputs 0, state IDLE, in_ready stays low until a key is reloaded.
REQ-038 With AES_DEC_ABORT_EN: abort on the 3rd BUSY cycle -> READY the next cycle, out_valid never asserts; then B.1 vectors decrypt correctly without reloading the key.
